// File: rtl/deal_sequencer_if.sv
// Dealer-side handshake bundle for deal_sequencer: deck clear pulse plus the
// draw request / acknowledge exchange carrying the dealt card id.
interface deal_sequencer_if;
    logic       deck_clear;
    logic       draw_req;
    logic       draw_ack;
    logic       draw_ok;
    logic [5:0] draw_card;

    modport master (
        output deck_clear,
        output draw_req,
        input  draw_ack,
        input  draw_ok,
        input  draw_card
    );

    modport slave (
        input  deck_clear,
        input  draw_req,
        output draw_ack,
        output draw_ok,
        output draw_card
    );
endinterface

// File: rtl/deal_sequencer.sv
// Hand-level Texas Hold'em deal controller: hole cards, then flop/turn/river on advance.
// Define DEAL_BURN_EN to insert one burn draw ahead of the flop, turn and river.
module deal_sequencer #(
    parameter int NUM_PLAYERS = 4,
    parameter int MAX_RETRY   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_hand,
    input  logic             advance,
    deal_sequencer_if.master dealer,
    output logic [5:0]       card_out,
    output logic             card_valid,
    output logic [3:0]       card_dest,
    output logic [2:0]       street,
    output logic             wait_adv,
    output logic             busy,
    output logic             error
);
`ifdef DEAL_BURN_EN
    localparam bit BURN = 1'b1;
`else
    localparam bit BURN = 1'b0;
`endif
    localparam int HOLE  = 2 * NUM_PLAYERS;
    localparam int TOTAL = HOLE + (BURN ? 8 : 5);
    localparam int IW    = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, REQ, RESP, PAUSE, DONE, ERR} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [7:0]    retry;
    logic [8:0]    retry_inc;
    logic          resp_ok;

    assign retry_inc = {1'b0, retry} + 9'd1;

    // Draw indices at which a new street begins; with burns enabled these are the burn draws.
    function automatic logic is_street_start(input logic [IW-1:0] ix);
        int i;
        i = int'(ix);
        if (BURN) return (i == HOLE) || (i == HOLE + 4) || (i == HOLE + 6);
        return (i == HOLE) || (i == HOLE + 3) || (i == HOLE + 4);
    endfunction

    function automatic logic is_burn(input logic [IW-1:0] ix);
        return BURN && is_street_start(ix);
    endfunction

    function automatic logic [3:0] dest_of(input logic [IW-1:0] ix);
        int i;
        int slot;
        i = int'(ix);
        if (i < NUM_PLAYERS) return 4'(i);
        if (i < HOLE)        return 4'(i - NUM_PLAYERS);
        if (!BURN)              slot = i - HOLE;
        else if (i < HOLE + 4)  slot = i - HOLE - 1;
        else if (i < HOLE + 6)  slot = 3;
        else                    slot = 4;
        return 4'(8 + slot);
    endfunction

    // NOTE: every register here uses non-blocking assignment so all state and
    // outputs update together at the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            idx               <= '0;
            retry             <= '0;
            resp_ok           <= 1'b0;
            dealer.deck_clear <= 1'b0;
            dealer.draw_req   <= 1'b0;
            card_out          <= '0;
            card_valid        <= 1'b0;
            card_dest         <= '0;
            street            <= '0;
            wait_adv          <= 1'b0;
            busy              <= 1'b0;
            error             <= 1'b0;
        end else begin
            dealer.deck_clear <= 1'b0;
            card_valid        <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (new_hand) begin
                        state             <= CLEAR;
                        idx               <= '0;
                        retry             <= '0;
                        dealer.deck_clear <= 1'b1;
                        street            <= 3'd1;
                        busy              <= 1'b1;
                        error             <= 1'b0;
                    end
                end
                CLEAR: begin
                    state           <= REQ;
                    dealer.draw_req <= 1'b1;
                end
                REQ: begin
                    if (dealer.draw_ack) begin
                        dealer.draw_req <= 1'b0;
                        resp_ok         <= dealer.draw_ok;
                        if (dealer.draw_ok) begin
                            state <= RESP;
                            retry <= '0;
                            idx   <= idx + 1'b1;
                            if (!is_burn(idx)) begin
                                card_out   <= dealer.draw_card;
                                card_valid <= 1'b1;
                                card_dest  <= dest_of(idx);
                            end
                        end else if (retry_inc > 9'(MAX_RETRY)) begin
                            state  <= ERR;
                            street <= 3'd7;
                            busy   <= 1'b0;
                            error  <= 1'b1;
                        end else begin
                            state <= RESP;
                            retry <= retry_inc[7:0];
                        end
                    end
                end
                RESP: begin
                    if (!resp_ok) begin
                        state           <= REQ;
                        dealer.draw_req <= 1'b1;
                    end else if (int'(idx) == TOTAL) begin
                        state  <= DONE;
                        street <= 3'd5;
                        busy   <= 1'b0;
                    end else if (is_street_start(idx)) begin
                        state    <= PAUSE;
                        wait_adv <= 1'b1;
                    end else begin
                        state           <= REQ;
                        dealer.draw_req <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (advance) begin
                        state           <= REQ;
                        dealer.draw_req <= 1'b1;
                        wait_adv        <= 1'b0;
                        street          <= street + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_deal_sequencer.sv
// Self-checking bench for deal_sequencer: scenario table driving a behavioural
// dealer, scoreboard of expected card/destination pairs, plus hand-written corner cases.
`timescale 1ns/1ps
module tb_deal_sequencer;
    localparam int N  = 4;
    localparam int MR = 3;
`ifdef DEAL_BURN_EN
    localparam int BURNS = 3;
`else
    localparam int BURNS = 0;
`endif
    localparam logic [3:0] BURN_MARK = 4'hF;

    typedef struct {
        logic [5:0] card;
        logic [3:0] dest;
    } sb_item_t;

    typedef struct {
        int lat;
        int fail_per;
        int fail_cards;
        bit always_fail;
        bit stray_adv;
        bit stray_ack;
        int exp_valid;
        int exp_acks;
        int exp_street;
        bit exp_error;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       new_hand;
    logic       advance;
    logic [5:0] card_out;
    logic       card_valid;
    logic [3:0] card_dest;
    logic [2:0] street;
    logic       wait_adv;
    logic       busy;
    logic       error;

    deal_sequencer_if dl();

    deal_sequencer #(.NUM_PLAYERS(N), .MAX_RETRY(MR)) dut (
        .clk        (clk),
        .reset      (reset),
        .new_hand   (new_hand),
        .advance    (advance),
        .dealer     (dl.master),
        .card_out   (card_out),
        .card_valid (card_valid),
        .card_dest  (card_dest),
        .street     (street),
        .wait_adv   (wait_adv),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    sb_item_t   sb[$];
    logic [3:0] plan[$];

    int         lat, fail_per, fail_cards;
    bit         always_fail, stray_ack;
    int         req_cycles, fail_left, good_cnt;
    int         n_ack, n_valid, n_clear;
    logic [5:0] next_card = 6'd5;
    bit         pend_valid, pend_ack, prev_req;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Dealer model and output monitor share one process so their ordering is fixed.
    always @(negedge clk) begin
        sb_item_t   item;
        logic [3:0] d;
        if (reset) begin
            dl.draw_ack  = 1'b0;
            dl.draw_ok   = 1'b0;
            dl.draw_card = 6'd0;
            req_cycles   = 0;
            pend_valid   = 1'b0;
            pend_ack     = 1'b0;
            prev_req     = 1'b0;
        end else begin
            if (pend_valid) check("valid_after_ack", int'(card_valid), 1);
            if (pend_ack)      check("req_low_in_resp", int'(dl.draw_req), 0);
            else if (prev_req) check("req_held", int'(dl.draw_req), 1);
            if (card_valid) begin
                n_valid++;
                check("valid_has_ack", int'(pend_valid), 1);
                check("sb_has_entry", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    item = sb.pop_front();
                    check("card_out", int'(card_out), int'(item.card));
                    check("card_dest", int'(card_dest), int'(item.dest));
                end
            end
            if (dl.deck_clear) n_clear++;
            if (error) check("err_req_low", int'(dl.draw_req), 0);

            prev_req    = dl.draw_req;
            pend_valid  = 1'b0;
            pend_ack    = 1'b0;
            dl.draw_ack = 1'b0;
            dl.draw_ok  = 1'b0;
            if (dl.draw_req) begin
                if (req_cycles >= lat) begin
                    dl.draw_ack = 1'b1;
                    pend_ack    = 1'b1;
                    req_cycles  = 0;
                    n_ack++;
                    if (always_fail || fail_left > 0) begin
                        if (fail_left > 0) fail_left--;
                    end else begin
                        dl.draw_ok   = 1'b1;
                        dl.draw_card = next_card;
                        check("draw_in_plan", int'(plan.size() != 0), 1);
                        if (plan.size() != 0) d = plan.pop_front();
                        else                  d = BURN_MARK;
                        if (d != BURN_MARK) begin
                            sb.push_back('{card: next_card, dest: d});
                            pend_valid = 1'b1;
                        end
                        next_card = 6'((int'(next_card) + 7) % 52);
                        good_cnt++;
                        if (good_cnt < fail_cards) fail_left = fail_per;
                    end
                end else begin
                    req_cycles++;
                end
            end else if (stray_ack) begin
                dl.draw_ack  = 1'b1;
                dl.draw_ok   = 1'b1;
                dl.draw_card = 6'd51;
            end
        end
    end

    task automatic start_hand();
        plan.delete();
        sb.delete();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++) plan.push_back(4'(p));
        if (BURNS != 0) plan.push_back(BURN_MARK);
        plan.push_back(4'd8);
        plan.push_back(4'd9);
        plan.push_back(4'd10);
        if (BURNS != 0) plan.push_back(BURN_MARK);
        plan.push_back(4'd11);
        if (BURNS != 0) plan.push_back(BURN_MARK);
        plan.push_back(4'd12);
        n_ack     = 0;
        n_valid   = 0;
        n_clear   = 0;
        good_cnt  = 0;
        fail_left = (fail_cards > 0) ? fail_per : 0;
        @(negedge clk);
        new_hand = 1'b1;
        @(negedge clk);
        new_hand = 1'b0;
        check("clear_pulse", int'(dl.deck_clear), 1);
        check("clear_street", int'(street), 1);
        check("clear_no_req", int'(dl.draw_req), 0);
        check("clear_busy", int'(busy), 1);
        check("clear_no_err", int'(error), 0);
        @(negedge clk);
        check("req_after_clear", int'(dl.draw_req), 1);
        check("clear_one_cycle", int'(dl.deck_clear), 0);
    endtask

    task automatic finish_hand(input bit stray_adv, output int pauses);
        bit done = 1'b0;
        bit adv_chk = 1'b0;
        bit stray_chk = 1'b0;
        bit stray_done = 1'b0;
        pauses = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            advance = 1'b0;
            if (adv_chk) begin
                check("street_after_adv", int'(street), pauses + 1);
                check("pause_left", int'(wait_adv), 0);
                adv_chk = 1'b0;
            end
            if (stray_chk) begin
                check("stray_adv_street", int'(street), 1);
                stray_chk = 1'b0;
            end
            if (error || (street == 3'd5 && !busy)) begin
                done = 1'b1;
            end else if (wait_adv) begin
                check("pause_street", int'(street), pauses + 1);
                pauses++;
                advance = 1'b1;
                adv_chk = 1'b1;
            end else if (stray_adv && !stray_done && street == 3'd1 && dl.draw_req) begin
                advance    = 1'b1;
                stray_done = 1'b1;
                stray_chk  = 1'b1;
            end
        end
        advance = 1'b0;
        check("hand_finished", int'(done), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t vecs[6];
        int   pauses;
        bit   hit;

        reset       = 1'b1;
        new_hand    = 1'b0;
        advance     = 1'b0;
        lat         = 0;
        fail_per    = 0;
        fail_cards  = 0;
        always_fail = 1'b0;
        stray_ack   = 1'b0;

        //         lat fpr fcd afl sad sak valid  acks                  street err
        vecs[0] = '{0,  0,  0,  0,  0,  0,  2*N+5, 2*N+5+BURNS,         5,     0};
        vecs[1] = '{3,  0,  0,  0,  0,  0,  2*N+5, 2*N+5+BURNS,         5,     0};
        vecs[2] = '{0,  2,  1,  0,  0,  0,  2*N+5, 2*N+5+BURNS+2,       5,     0};
        vecs[3] = '{0,  3,  2,  0,  0,  0,  2*N+5, 2*N+5+BURNS+6,       5,     0};
        vecs[4] = '{1,  0,  0,  0,  1,  1,  2*N+5, 2*N+5+BURNS,         5,     0};
        vecs[5] = '{0,  0,  0,  1,  0,  0,  0,     MR+1,                7,     1};

        repeat (3) @(negedge clk);
        check("rst_deck_clear", int'(dl.deck_clear), 0);
        check("rst_draw_req", int'(dl.draw_req), 0);
        check("rst_card_out", int'(card_out), 0);
        check("rst_card_valid", int'(card_valid), 0);
        check("rst_card_dest", int'(card_dest), 0);
        check("rst_street", int'(street), 0);
        check("rst_wait_adv", int'(wait_adv), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_error", int'(error), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_req", int'(dl.draw_req), 0);

        foreach (vecs[i]) begin
            lat         = vecs[i].lat;
            fail_per    = vecs[i].fail_per;
            fail_cards  = vecs[i].fail_cards;
            always_fail = vecs[i].always_fail;
            stray_ack   = vecs[i].stray_ack;
            start_hand();
            finish_hand(vecs[i].stray_adv, pauses);
            check($sformatf("v%0d_valid", i), n_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_acks", i), n_ack, vecs[i].exp_acks);
            check($sformatf("v%0d_street", i), int'(street), vecs[i].exp_street);
            check($sformatf("v%0d_error", i), int'(error), int'(vecs[i].exp_error));
            check($sformatf("v%0d_pauses", i), pauses, vecs[i].exp_error ? 0 : 3);
            check($sformatf("v%0d_clears", i), n_clear, 1);
            check($sformatf("v%0d_sb_drained", i), sb.size(), 0);
            check($sformatf("v%0d_req_idle", i), int'(dl.draw_req), 0);
            check($sformatf("v%0d_busy_idle", i), int'(busy), 0);
        end

        // Recovery from the sticky error state with a healthy dealer.
        always_fail = 1'b0;
        stray_ack   = 1'b0;
        lat         = 0;
        start_hand();
        finish_hand(1'b0, pauses);
        check("recover_valid", n_valid, 2 * N + 5);
        check("recover_street", int'(street), 5);
        check("recover_error", int'(error), 0);
        check("recover_clears", n_clear, 1);

        // Reset part-way through the flop.
        start_hand();
        hit = 1'b0;
        for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
            @(negedge clk);
            advance = 1'b0;
            if (wait_adv) advance = 1'b1;
            else if (street == 3'd2 && n_valid >= 2 * N + 1) hit = 1'b1;
        end
        advance = 1'b0;
        check("reached_flop", int'(hit), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_deck_clear", int'(dl.deck_clear), 0);
        check("mid_rst_draw_req", int'(dl.draw_req), 0);
        check("mid_rst_card_out", int'(card_out), 0);
        check("mid_rst_card_valid", int'(card_valid), 0);
        check("mid_rst_card_dest", int'(card_dest), 0);
        check("mid_rst_street", int'(street), 0);
        check("mid_rst_wait_adv", int'(wait_adv), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_error", int'(error), 0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        plan.delete();
        repeat (3) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_req", int'(dl.draw_req), 0);
        check("post_rst_street", int'(street), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/deal_sequencer.md
# deal_sequencer

Hand-level controller for the card dealer datapath. Runs one Texas Hold'em hand:
- clears the deck;
- requests hole cards round-robin for `NUM_PLAYERS` players;
- then deals flop, turn and river, each on an external `advance` command.

It retries dealer collisions, tags every delivered card with its destination, and flags an error when the dealer cannot produce a card. It sits between the table/game FSM and the card dealer.

## Interface
- `NUM_PLAYERS`, 4, players at table, legal 2..8
- `MAX_RETRY`, 15, collisions tolerated per card before error, legal 1..255
- `clk` in 1 system clock
- `reset` in 1 synchronous, active-high
- `new_hand` in 1 start a hand; honoured only in IDLE, DONE or ERR
- `advance` in 1 deal next street; honoured only in PAUSE
- `deck_clear` out 1 one-cycle pulse to dealer: clear dealt flags
- `draw_req` out 1 draw request to dealer, level
- `draw_ack` in 1 dealer response strobe, one cycle
- `draw_ok` in 1 qualifies `draw_ack`: 1 = card dealt, 0 = collision
- `draw_card` in 6 card id 0..51, valid with `draw_ack && draw_ok`
- `card_out` out 6 registered delivered card
- `card_valid` out 1 one-cycle strobe for `card_out`/`card_dest`
- `card_dest` out 4 0..NUM_PLAYERS-1 = player; 8..12 = board slot 0..4
- `street` out 3 0 idle, 1 hole, 2 flop, 3 turn, 4 river, 5 done, 7 error
- `wait_adv` out 1 high in PAUSE
- `busy` out 1 high in any state other than IDLE, DONE, ERR
- `error` out 1 high in ERR

## Operation
- States: IDLE, CLEAR, REQ, RESP, PAUSE, DONE, ERR.
- `new_hand` accepted: CLEAR for one cycle (`deck_clear`=1, `street`=1), then REQ.
- REQ: `draw_req`=1 held until an edge samples `draw_ack`=1, then RESP for one cycle with `draw_req`=0.
- Good ack (`draw_ok`=1):
  - in RESP, `card_out`=`draw_card`, `card_valid`=1 with `card_dest` (burns excepted);
  - retry counter cleared;
  - card index incremented.
- Collision (`draw_ok`=0):
  - retry counter incremented; no `card_valid`;
  - if the counter exceeds `MAX_RETRY`, go to ERR, otherwise REQ after RESP.
- Card order (hole street):
  - first card to players 0..N-1 in order, then second card to players 0..N-1;
  - `card_dest` = index mod N.
- After the last hole card: PAUSE.
- `advance` in PAUSE steps to the next street: flop (3 cards, dest 8,9,10), turn (dest 11), river (dest 12).
- After the river: DONE, `street`=5.
- `street` changes in the cycle after `advance`; during PAUSE it holds the value of the street just dealt.
- ERR: sticky until `new_hand` or `reset`; `draw_req`=0.
- Ignored inputs:
  - `new_hand` while `busy`;
  - `advance` outside PAUSE;
  - `draw_ack` while `draw_req`=0.
- Retry counter is 8 bits wide and saturates in the compare; indices use counters sized for 2N+8 draws.

## Timing
- Reset values: `deck_clear`=0, `draw_req`=0, `card_out`=0, `card_valid`=0, `card_dest`=0, `street`=0, `wait_adv`=0, `busy`=0, `error`=0; state IDLE, counters 0.
- Reset mid-hand aborts next cycle with no `deck_clear`; the dealer is reset separately.
- `new_hand` at edge t: `deck_clear` high in cycle t+1, `draw_req` high from t+2.
- Ack sampled at edge k: `draw_req` low in cycle k+1 (RESP); `draw_req` high again from k+2 if more draws remain.
- Each draw therefore takes a minimum of 2 cycles with zero-latency ack.
- `draw_ack` combinationally high in the same cycle as `draw_req` is legal.
- All outputs are registered; there is no combinational input-to-output path.
- Simultaneous `advance` and `new_hand` in PAUSE: `advance` wins, since `new_hand` is ignored while busy.

## Configuration
- `DEAL_BURN_EN` defined: one burn draw precedes the flop, turn and river.
  - Burn draws follow the same handshake and retry rules.
  - Burn cards produce no `card_valid`.
  - Total draws per hand = 2N+8.
- `DEAL_BURN_EN` undefined: no burns; total draws = 2N+5.

## Test plan
- Zero-latency dealer always ok, N=4, no burn, `new_hand` then `advance` ×3:
  - 13 `card_valid` strobes;
  - dests 0,1,2,3,0,1,2,3, PAUSE, 8,9,10, PAUSE, 11, PAUSE, 12;
  - `street` ends 5; exactly one `deck_clear`.
- Dealer acks after 3 cycles:
  - `draw_req` held high for all 4 cycles;
  - `card_valid` one cycle after the ack edge;
  - no duplicate strobes.
- Dealer returns `draw_ok`=0 twice then 1 on the first hole card, `MAX_RETRY`=15:
  - three requests, one `card_valid` to dest 0;
  - the retry counter does not carry into card 2.
- Dealer always `draw_ok`=0, `MAX_RETRY`=3:
  - ERR after the 4th collision; `error`=1, `street`=7, `draw_req`=0;
  - `new_hand` recovers with a fresh `deck_clear`.
- Stray inputs:
  - `reset` asserted mid-flop → all outputs 0 next cycle;
  - `advance` during hole dealing ignored;
  - `draw_ack` with `draw_req`=0 ignored.
- `DEAL_BURN_EN` defined, N=2:
  - 12 draws, 9 `card_valid`;
  - no strobe on the first draw after each `advance`.
